// File: rtl/voice_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator_pkg
// Brief    : Shared register map, FSM encoding and write-list types for the
//            voice allocator.
// Revision : 1.0
// ============================================================================
package voice_allocator_pkg;

    localparam int VIDX_W = 4;

    localparam logic [1:0] CTRL_OFS = 2'd0;
    localparam logic [1:0] KEY_OFS  = 2'd1;
    localparam logic [1:0] VEL_OFS  = 2'd2;

    localparam int         GATE_BIT = 0;
    localparam logic [7:0] GATE_ON  = 8'(1 << GATE_BIT);
    localparam logic [7:0] GATE_OFF = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOOKUP    = 2'd1,
        S_WR_SETUP  = 2'd2,
        S_WR_STROBE = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0] ofs;
        logic [7:0] data;
    } wr_entry_t;

    function automatic wr_entry_t make_entry(input logic [1:0] ofs, input logic [7:0] data);
        wr_entry_t e;
        e.ofs  = ofs;
        e.data = data;
        return e;
    endfunction

    function automatic logic [15:0] voice_addr(input logic [15:0]       base,
                                               input logic [15:0]       stride,
                                               input logic [VIDX_W-1:0] v,
                                               input logic [1:0]        ofs);
        return base + stride * {12'd0, v} + {14'd0, ofs};
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator_if
// Brief    : Note-event handshake plus channel register bus of the allocator.
// Revision : 1.0
// ============================================================================
interface voice_allocator_if #(
    parameter int NUM_VOICES = 2
);
    logic                  note_valid;
    logic                  note_ready;
    logic                  note_on;
    logic [6:0]            note_key;
    logic [6:0]            note_vel;
    logic                  note_dropped;
    logic [15:0]           bus_address;
    logic [7:0]            bus_data;
    logic                  bus_read_write;
    logic                  bus_clock;
    logic [NUM_VOICES-1:0] active_mask;

    // master = allocator side (owns the channel bus)
    modport master (
        input  note_valid, note_on, note_key, note_vel,
        output note_ready, note_dropped, bus_address, bus_data,
               bus_read_write, bus_clock, active_mask
    );

    modport slave (
        output note_valid, note_on, note_key, note_vel,
        input  note_ready, note_dropped, bus_address, bus_data,
               bus_read_write, bus_clock, active_mask
    );
endinterface
`default_nettype wire

// File: rtl/voice_allocator_voice_select.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator_voice_select
// Brief    : Combinational search for a free voice, the oldest voice and the
//            lowest active voice holding a given key.
// Revision : 1.0
// ============================================================================
module voice_allocator_voice_select
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 2,
    parameter int AGE_W      = 8
) (
    input  wire logic [NUM_VOICES-1:0]            active_i,
    input  wire logic [NUM_VOICES-1:0][AGE_W-1:0] ages_i,
    input  wire logic [NUM_VOICES-1:0][6:0]       keys_i,
    input  wire logic [6:0]                       key_i,
    output logic      [VIDX_W-1:0]                free_idx_o,
    output logic                                  free_found_o,
    output logic      [VIDX_W-1:0]                oldest_idx_o,
    output logic      [VIDX_W-1:0]                match_idx_o,
    output logic                                  match_found_o
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        free_idx_o    = '0;
        free_found_o  = 1'b0;
        match_idx_o   = '0;
        match_found_o = 1'b0;
        oldest_idx_o  = '0;
        best_age      = ages_i[0];

        // Scanning downward leaves the lowest qualifying index as the winner.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_i[v]) begin
                free_found_o = 1'b1;
                free_idx_o   = VIDX_W'(v);
            end
            if (active_i[v] && (keys_i[v] == key_i)) begin
                match_found_o = 1'b1;
                match_idx_o   = VIDX_W'(v);
            end
        end

        // Strict compare keeps the lowest index on an age tie.
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (ages_i[v] > best_age) begin
                best_age     = ages_i[v];
                oldest_idx_o = VIDX_W'(v);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Brief    : Assigns note-on/off events to synth voices and drives the channel
//            register bus. Define VOICE_STEAL_EN to steal the oldest voice.
// Revision : 1.0
// ============================================================================
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int          NUM_VOICES = 2,
    parameter logic [15:0] BASE_ADDR  = 16'h0010,
    parameter logic [15:0] STRIDE     = 16'h0020,
    parameter int          AGE_W      = 8
) (
    input wire logic          clk,
    input wire logic          rst_n,
    voice_allocator_if.master ev_bus
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    state_e                           state_q, state_d;
    logic                             on_q;
    logic [6:0]                       key_q, vel_q;
    logic [VIDX_W-1:0]                voice_q, voice_d;
    wr_entry_t [3:0]                  list_q, list_d;
    logic [1:0]                       ptr_q, ptr_d;
    logic [1:0]                       last_q, last_d;
    logic [NUM_VOICES-1:0]            active_q, active_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0] ages_q, ages_d;
    logic [NUM_VOICES-1:0][6:0]       keys_q, keys_d;
    logic                             drop_d;

    logic                             ready_q, dropped_q;
    logic [15:0]                      bus_addr_q;
    logic [7:0]                       bus_data_q;
    logic                             bus_rw_q, bus_clk_q;

    logic [VIDX_W-1:0]                free_idx, oldest_idx, match_idx;
    logic                             free_found, match_found;
    logic                             accept;

    assign accept = ev_bus.note_valid && ready_q;

    voice_allocator_voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W)
    ) u_voice_select (
        .active_i      (active_q),
        .ages_i        (ages_q),
        .keys_i        (keys_q),
        .key_i         (key_q),
        .free_idx_o    (free_idx),
        .free_found_o  (free_found),
        .oldest_idx_o  (oldest_idx),
        .match_idx_o   (match_idx),
        .match_found_o (match_found)
    );

`ifndef VOICE_STEAL_EN
    logic unused_oldest;
    assign unused_oldest = ^oldest_idx;
`endif

    always_comb begin
        state_d  = state_q;
        voice_d  = voice_q;
        list_d   = list_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        active_d = active_q;
        ages_d   = ages_q;
        keys_d   = keys_q;
        drop_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                state_d = S_WR_SETUP;
                ptr_d   = 2'd0;
                if (on_q) begin
                    if (free_found) begin
                        voice_d   = free_idx;
                        list_d[0] = make_entry(KEY_OFS, {1'b0, key_q});
                        list_d[1] = make_entry(VEL_OFS, {1'b0, vel_q});
                        list_d[2] = make_entry(CTRL_OFS, GATE_ON);
                        last_d    = 2'd2;
                    end else begin
`ifdef VOICE_STEAL_EN
                        voice_d   = oldest_idx;
                        list_d[0] = make_entry(CTRL_OFS, GATE_OFF);
                        list_d[1] = make_entry(KEY_OFS, {1'b0, key_q});
                        list_d[2] = make_entry(VEL_OFS, {1'b0, vel_q});
                        list_d[3] = make_entry(CTRL_OFS, GATE_ON);
                        last_d    = 2'd3;
`else
                        state_d   = S_IDLE;
                        drop_d    = 1'b1;
`endif
                    end
                end else if (match_found) begin
                    voice_d   = match_idx;
                    list_d[0] = make_entry(CTRL_OFS, GATE_OFF);
                    last_d    = 2'd0;
                end else begin
                    state_d = S_IDLE;
                    drop_d  = 1'b1;
                end
            end

            S_WR_SETUP: begin
                state_d = S_WR_STROBE;
            end

            S_WR_STROBE: begin
                if (ptr_q == last_q) begin
                    state_d = S_IDLE;
                    // Voice bookkeeping commits with the final gate strobe.
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (VIDX_W'(v) == voice_q) begin
                            active_d[v] = on_q;
                            ages_d[v]   = '0;
                            if (on_q) begin
                                keys_d[v] = key_q;
                            end
                        end else if (on_q) begin
                            if (!active_q[v]) begin
                                ages_d[v] = '0;
                            end else if (ages_q[v] != AGE_MAX) begin
                                ages_d[v] = ages_q[v] + 1'b1;
                            end
                        end
                    end
                end else begin
                    ptr_d   = ptr_q + 2'd1;
                    state_d = S_WR_SETUP;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            on_q       <= 1'b0;
            key_q      <= '0;
            vel_q      <= '0;
            voice_q    <= '0;
            list_q     <= '0;
            ptr_q      <= '0;
            last_q     <= '0;
            active_q   <= '0;
            ages_q     <= '0;
            keys_q     <= '0;
            ready_q    <= 1'b0;
            dropped_q  <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_rw_q   <= 1'b0;
            bus_clk_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            voice_q  <= voice_d;
            list_q   <= list_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            active_q <= active_d;
            ages_q   <= ages_d;
            keys_q   <= keys_d;
            if (accept) begin
                on_q  <= ev_bus.note_on;
                key_q <= ev_bus.note_key;
                vel_q <= ev_bus.note_vel;
            end

            // Outputs are registered from next-state so the strobe is glitch-free.
            ready_q   <= (state_d == S_IDLE);
            dropped_q <= drop_d;
            bus_rw_q  <= (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE);
            bus_clk_q <= (state_d == S_WR_STROBE);
            if (state_d == S_WR_SETUP) begin
                bus_addr_q <= voice_addr(BASE_ADDR, STRIDE, voice_d, list_d[ptr_d].ofs);
                bus_data_q <= list_d[ptr_d].data;
            end
        end
    end

    assign ev_bus.note_ready     = ready_q;
    assign ev_bus.note_dropped   = dropped_q;
    assign ev_bus.bus_address    = bus_addr_q;
    assign ev_bus.bus_data       = bus_data_q;
    assign ev_bus.bus_read_write = bus_rw_q;
    assign ev_bus.bus_clock      = bus_clk_q;
    assign ev_bus.active_mask    = active_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Directed self-checking bench for voice_allocator (2 voices).
// Revision : 1.0
// ============================================================================
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] wq[$];
    logic [23:0] exp_q[$];
    logic        prev_setup = 1'b0;
    logic [23:0] setup_word = '0;
    int          seq_bad = 0;
    int          lat;
    logic        drop;

    voice_allocator_if #(.NUM_VOICES(2)) ev_bus();

    voice_allocator #(
        .NUM_VOICES (2),
        .BASE_ADDR  (16'h0010),
        .STRIDE     (16'h0020),
        .AGE_W      (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ev_bus (ev_bus)
    );

    always #5 clk = ~clk;

    // Bus monitor: every strobe must be preceded by a setup cycle with the same word.
    always @(negedge clk) begin
        if (ev_bus.bus_clock === 1'b1) begin
            wq.push_back({ev_bus.bus_address, ev_bus.bus_data});
            if (!prev_setup || ev_bus.bus_read_write !== 1'b1 ||
                setup_word !== {ev_bus.bus_address, ev_bus.bus_data})
                seq_bad <= seq_bad + 1;
            prev_setup <= 1'b0;
        end else begin
            prev_setup <= (ev_bus.bus_read_write === 1'b1);
            setup_word <= {ev_bus.bus_address, ev_bus.bus_data};
        end
    end

    task automatic send_event(input logic on, input logic [6:0] key, input logic [6:0] vel,
                              output int lat_o, output logic drop_o);
        int n = 0;
        wq.delete();
        ev_bus.note_on    = on;
        ev_bus.note_key   = key;
        ev_bus.note_vel   = vel;
        ev_bus.note_valid = 1'b1;
        while (ev_bus.note_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        ev_bus.note_valid = 1'b0;
        lat_o = 1;
        while (ev_bus.note_ready !== 1'b1 && lat_o < 50) begin
            @(posedge clk); #1; lat_o++;
        end
        drop_o = ev_bus.note_dropped;
    endtask

    task automatic do_reset();
        ev_bus.note_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ev_bus.note_valid = 1'b0;
        ev_bus.note_on    = 1'b0;
        ev_bus.note_key   = '0;
        ev_bus.note_vel   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ev_bus.note_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ev_bus.note_ready); end
        checks++; if (ev_bus.bus_address !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", ev_bus.bus_address); end
        checks++; if ({ev_bus.bus_data, ev_bus.bus_read_write, ev_bus.bus_clock, ev_bus.note_dropped} !== 11'h0) begin
            errors++; $display("FAIL reset_bus: data=%h rw=%b clk=%b drop=%b expected all 0",
                               ev_bus.bus_data, ev_bus.bus_read_write, ev_bus.bus_clock, ev_bus.note_dropped); end
        checks++; if (ev_bus.active_mask !== 2'b00) begin errors++; $display("FAIL reset_mask: got %b expected 00", ev_bus.active_mask); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ev_bus.note_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", ev_bus.note_ready); end
    endtask

    task automatic test_note_on_free();
        send_event(1'b1, 7'd60, 7'd100, lat, drop);
        exp_q = {24'h00113C, 24'h001264, 24'h001001};
        checks++; if (lat !== 8) begin errors++; $display("FAIL on_free_latency: got %0d expected 8", lat); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL on_free_drop: got %b expected 0", drop); end
        checks++; if (ev_bus.active_mask !== 2'b01) begin errors++; $display("FAIL on_free_mask: got %b expected 01", ev_bus.active_mask); end
        checks++;
        if (wq.size() != exp_q.size()) begin errors++; $display("FAIL on_free_count: got %0d writes expected %0d", wq.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (wq[i] !== exp_q[i]) begin errors++; $display("FAIL on_free_write%0d: got %h expected %h", i, wq[i], exp_q[i]); end
        end
        checks++; if (seq_bad != 0) begin errors++; $display("FAIL on_free_timing: got %0d bad strobes expected 0", seq_bad); end
    endtask

    task automatic test_second_note_on();
        send_event(1'b1, 7'd64, 7'd90, lat, drop);
        exp_q = {24'h003140, 24'h00325A, 24'h003001};
        checks++; if (lat !== 8) begin errors++; $display("FAIL on_second_latency: got %0d expected 8", lat); end
        checks++; if (ev_bus.active_mask !== 2'b11) begin errors++; $display("FAIL on_second_mask: got %b expected 11", ev_bus.active_mask); end
        checks++; if (dut.ages_q[0] !== 8'd1) begin errors++; $display("FAIL on_second_age0: got %0d expected 1", dut.ages_q[0]); end
        checks++;
        if (wq.size() != exp_q.size()) begin errors++; $display("FAIL on_second_count: got %0d writes expected %0d", wq.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (wq[i] !== exp_q[i]) begin errors++; $display("FAIL on_second_write%0d: got %h expected %h", i, wq[i], exp_q[i]); end
        end
    endtask

    task automatic test_note_off_hit();
        send_event(1'b0, 7'd60, 7'd0, lat, drop);
        checks++; if (lat !== 4) begin errors++; $display("FAIL off_hit_latency: got %0d expected 4", lat); end
        checks++; if (ev_bus.active_mask !== 2'b10) begin errors++; $display("FAIL off_hit_mask: got %b expected 10", ev_bus.active_mask); end
        checks++;
        if (wq.size() != 1) begin errors++; $display("FAIL off_hit_count: got %0d writes expected 1", wq.size()); end
        else if (wq[0] !== 24'h001000) begin errors++; $display("FAIL off_hit_write: got %h expected 001000", wq[0]); end
    endtask

    task automatic test_note_off_miss();
        send_event(1'b0, 7'd99, 7'd0, lat, drop);
        checks++; if (lat !== 2) begin errors++; $display("FAIL off_miss_latency: got %0d expected 2", lat); end
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL off_miss_drop: got %b expected 1", drop); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL off_miss_writes: got %0d writes expected 0", wq.size()); end
        @(posedge clk); #1;
        checks++; if (ev_bus.note_dropped !== 1'b0) begin errors++; $display("FAIL off_miss_pulse_width: got %b expected 0", ev_bus.note_dropped); end
        checks++; if (ev_bus.active_mask !== 2'b10) begin errors++; $display("FAIL off_miss_mask: got %b expected 10", ev_bus.active_mask); end
    endtask

    // Event A (on 40) then event B held during A's busy time with a wandering key.
    task automatic test_back_to_back();
        int n = 0;
        wq.delete();
        ev_bus.note_on    = 1'b1;
        ev_bus.note_key   = 7'd40;
        ev_bus.note_vel   = 7'd11;
        ev_bus.note_valid = 1'b1;
        while (ev_bus.note_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        n = 0;
        while (ev_bus.note_ready !== 1'b1 && n < 50) begin
            ev_bus.note_on  = n[0];
            ev_bus.note_key = n[0] ? 7'd99 : 7'd64;
            ev_bus.note_vel = 7'(n + 20);
            @(posedge clk); #1; n++;
        end
        ev_bus.note_on  = 1'b0;
        ev_bus.note_key = 7'd40;
        ev_bus.note_vel = 7'd0;
        @(posedge clk); #1;
        ev_bus.note_valid = 1'b0;
        ev_bus.note_key   = 7'd64;
        n = 0;
        while (ev_bus.note_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        exp_q = {24'h001128, 24'h00120B, 24'h001001, 24'h001000};
        checks++; if (ev_bus.active_mask !== 2'b10) begin errors++; $display("FAIL b2b_mask: got %b expected 10", ev_bus.active_mask); end
        checks++;
        if (wq.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d writes expected %0d", wq.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (wq[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write%0d: got %h expected %h", i, wq[i], exp_q[i]); end
        end
        checks++; if (seq_bad != 0) begin errors++; $display("FAIL b2b_timing: got %0d bad strobes expected 0", seq_bad); end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        ev_bus.note_on    = 1'b1;
        ev_bus.note_key   = 7'd33;
        ev_bus.note_vel   = 7'd44;
        ev_bus.note_valid = 1'b1;
        while (ev_bus.note_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        ev_bus.note_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({ev_bus.bus_clock, ev_bus.bus_address, ev_bus.bus_data} !== {1'b1, 16'h0011, 8'h21}) begin
            errors++; $display("FAIL midrst_strobe: clk=%b addr=%h data=%h expected 1 0011 21",
                               ev_bus.bus_clock, ev_bus.bus_address, ev_bus.bus_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (ev_bus.bus_clock !== 1'b0) begin errors++; $display("FAIL midrst_busclock: got %b expected 0", ev_bus.bus_clock); end
        checks++; if ({ev_bus.bus_address, ev_bus.bus_data, ev_bus.bus_read_write, ev_bus.note_ready, ev_bus.active_mask} !== 28'h0) begin
            errors++; $display("FAIL midrst_outputs: addr=%h data=%h rw=%b rdy=%b mask=%b expected all 0",
                               ev_bus.bus_address, ev_bus.bus_data, ev_bus.bus_read_write, ev_bus.note_ready, ev_bus.active_mask); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ev_bus.active_mask !== 2'b00) begin errors++; $display("FAIL midrst_mask: got %b expected 00", ev_bus.active_mask); end
        checks++; if ({ev_bus.note_ready, ev_bus.bus_clock} !== 2'b10) begin
            errors++; $display("FAIL midrst_release: rdy=%b clk=%b expected 1 0", ev_bus.note_ready, ev_bus.bus_clock); end
    endtask

    task automatic test_steal();
        do_reset();
        seq_bad = 0;
        send_event(1'b1, 7'd60, 7'd100, lat, drop);
        send_event(1'b1, 7'd64, 7'd90, lat, drop);
        send_event(1'b1, 7'd67, 7'd50, lat, drop);
        checks++; if (ev_bus.active_mask !== 2'b11) begin errors++; $display("FAIL steal_mask: got %b expected 11", ev_bus.active_mask); end
`ifdef VOICE_STEAL_EN
        exp_q = {24'h001000, 24'h001143, 24'h001232, 24'h001001};
        checks++; if (lat !== 10) begin errors++; $display("FAIL steal_latency: got %0d expected 10", lat); end
        checks++; if ({dut.ages_q[1], dut.ages_q[0]} !== 16'h0100) begin
            errors++; $display("FAIL steal_ages: got v1=%0d v0=%0d expected v1=1 v0=0", dut.ages_q[1], dut.ages_q[0]); end
        checks++;
        if (wq.size() != exp_q.size()) begin errors++; $display("FAIL steal_count: got %0d writes expected %0d", wq.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (wq[i] !== exp_q[i]) begin errors++; $display("FAIL steal_write%0d: got %h expected %h", i, wq[i], exp_q[i]); end
        end
        checks++; if (seq_bad != 0) begin errors++; $display("FAIL steal_timing: got %0d bad strobes expected 0", seq_bad); end
`else
        checks++; if (lat !== 2) begin errors++; $display("FAIL nosteal_latency: got %0d expected 2", lat); end
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL nosteal_drop: got %b expected 1", drop); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL nosteal_writes: got %0d writes expected 0", wq.size()); end
`endif
    endtask

    initial begin
        test_reset();
        test_note_on_free();
        test_second_note_on();
        test_note_off_hit();
        test_note_off_miss();
        test_back_to_back();
        test_reset_mid_write();
        test_steal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Note-event controller that owns the channel register bus and assigns incoming note-on/note-off events to the NUM_VOICES synth channels.
- Tracks which voices are active, picks a free voice (or steals the oldest one), and issues the bus write sequences that gate each channel on or off.
- Sits between the note/event source and the channel array.
- Single master of BusAddress/BusData/BusReadWrite/BusClock.

Parameters:
- NUM_VOICES, 2, number of channels managed; 1..16.
- BASE_ADDR, 16'h0010, bus address of voice 0 register block.
- STRIDE, 16'h0020, address distance between consecutive voice blocks.
- AGE_W, 8, width of per-voice age counter (saturating).

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- NoteValid  in  1  event request; held until accepted.
- NoteReady  out  1  high when block can accept an event (IDLE state).
- NoteOn  in  1  1 = note-on, 0 = note-off.
- NoteKey  in  7  key number.
- NoteVel  in  7  velocity (note-on only).
- NoteDropped  out  1  one-cycle pulse when an event produces no bus traffic.
- BusAddress  out  16  register address.
- BusData  out  8  write data.
- BusReadWrite  out  1  1 = write; only writes are issued.
- BusClock  out  1  write strobe; data captured by channels on its rising edge.
- ActiveMask  out  NUM_VOICES  per-voice gate state.

Behaviour:
- Reset (async, Reset=0) values:
  - NoteReady=0, NoteDropped=0, BusAddress=0, BusData=0, BusReadWrite=0, BusClock=0, ActiveMask=0.
  - All ages 0, FSM in IDLE.
  - First cycle after release: NoteReady=1.
- Reset mid-operation abandons any partial write sequence immediately. BusClock is forced low; no further strobes.
- Handshake: event accepted on a cycle with NoteValid && NoteReady. Key, velocity and type are latched then. NoteReady drops the next cycle and stays low until return to IDLE.
- Voice register map, relative to voice base = BASE_ADDR + STRIDE*v:
  - +0: control, bit0 = gate.
  - +1: key.
  - +2: velocity.
  - Data is zero-extended to 8 bits.
- FSM states: IDLE -> LOOKUP -> WR_SETUP <-> WR_STROBE -> IDLE.
- LOOKUP (1 cycle) builds a write list of 1..4 entries:
  - Note-off, hit:
    - Lowest-index active voice with matching key.
    - List = [ctrl=0]; clear its active bit after the strobe.
  - Note-off, miss: no writes; NoteDropped pulses; go to IDLE.
  - Note-on, free voice exists:
    - Use the lowest-index inactive voice.
    - List = [key, vel, ctrl=1].
  - Note-on, all voices active (steal):
    - Victim = voice with the largest age; tie goes to the lowest index.
    - List = [ctrl=0, key, vel, ctrl=1].
- Write timing per list entry:
  - WR_SETUP cycle: BusAddress/BusData valid, BusReadWrite=1, BusClock=0.
  - WR_STROBE cycle: same address/data, BusClock=1.
  - Then the next entry, or IDLE. BusReadWrite returns to 0 in IDLE.
- Latency, acceptance to NoteReady high again:
  - Note-off hit: 4 cycles.
  - Free note-on: 8 cycles.
  - Steal: 10 cycles.
  - Miss: 2 cycles.
- Age and active-mask update (on the final ctrl=1 strobe of a note-on):
  - Target voice active=1, age=0.
  - Every other active voice age+1, saturating at 2^AGE_W-1.
  - Inactive voices hold age 0.
- ActiveMask updates on the cycle after the final gate strobe.
- Same key pressed twice allocates two voices; no dedup.
- NoteValid asserted while NoteReady=0 is ignored. The source holds it.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: steal behaviour as above.
- Undefined: note-on with all voices active produces no bus writes, pulses NoteDropped, and returns to IDLE after LOOKUP (2-cycle latency). Age logic is still maintained.

Decomposition:
- Shared package holds:
  - Register offsets: CTRL_OFS=0, KEY_OFS=1, VEL_OFS=2.
  - Gate bit index.
  - FSM state encoding.
  - Write-list entry typedef {offset, data}.
- One natural sub-module: voice_select (combinational). Inputs: active mask, ages, key. Outputs: free-voice index/found, oldest-voice index, key-match index/found.

Test Plan:
- Reset released, note-on key 60 vel 100 -> writes 0x0011=60, 0x0012=100, 0x0010=1 in that order, 2 cycles each; ActiveMask=2'b01; NoteReady high 8 cycles after accept.
- Second note-on key 64 vel 90 -> writes at 0x0031, 0x0032, 0x0030=1; ActiveMask=2'b11; voice 0 age=1.
- Note-off key 60 -> single write 0x0010=0; ActiveMask=2'b10; note-off key 99 -> NoteDropped pulse, no BusClock edge.
- Both active (voice0 older), note-on key 67 vel 50 with VOICE_STEAL_EN -> 0x0010=0, 0x0011=67, 0x0012=50, 0x0010=1; without the macro -> NoteDropped, no bus activity.
- Reset asserted on the WR_STROBE cycle of a key write -> BusClock=0 and all outputs at reset values immediately; ActiveMask=0 after release.
- NoteValid held through a busy period with changing NoteKey -> only the value present on the acceptance cycle is written.
